// File: rtl/uart_rx_os16.sv
// ----------------------------------------------------------------------------
// uart_rx_os16 -- oversampling UART receiver
//
// Recovers bytes from an asynchronous serial line. The line is resynchronised
// and then sampled OVER_SAMPLE times per bit. A start bit is accepted only if
// it is still low at tick MID_SAMPLE. Each data, parity and stop bit is then
// sampled one bit time later, which places every sample at its bit centre.
// The receiver returns to IDLE at the stop-bit midpoint, so a start edge that
// follows with no idle gap is still caught.
//
// Optional feature macro: UART_RX_PARITY_EN
//   If defined, one even-parity bit follows the data bits. A parity mismatch
//   raises o_frame_err in place of o_rx_done.
//   If undefined, frames are 8N1 and no parity logic is built.
//
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_rx_en      receive enable; 0 aborts any frame in progress
//   i_rx         serial line, idle high, asynchronous to i_clk
//   o_data       last correctly framed byte
//   o_rx_done    one-cycle pulse when o_data updates
//   o_frame_err  one-cycle pulse on a low stop bit (or a parity mismatch)
// ----------------------------------------------------------------------------
module uart_rx_os16 #(
    parameter int SIZE_DATA   = 8,
    parameter int OVER_SAMPLE = 16,
    parameter int MID_SAMPLE  = 8,
    parameter int DIV_SAMPLE  = 326
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx_en,
    input  logic                 i_rx,
    output logic [SIZE_DATA-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_err
);

    localparam int DIV_W = (DIV_SAMPLE  > 1) ? $clog2(DIV_SAMPLE)  : 1;
    localparam int OS_W  = (OVER_SAMPLE > 1) ? $clog2(OVER_SAMPLE) : 1;
    localparam int BIT_W = (SIZE_DATA   > 1) ? $clog2(SIZE_DATA)   : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_SAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVER_SAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_MID   = OS_W'(MID_SAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SIZE_DATA - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_e;

    state_e               state_q;
    logic [1:0]           sync_q;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [OS_W-1:0]      os_cnt_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic [SIZE_DATA-1:0] shift_q;
    logic [SIZE_DATA-1:0] data_q;
    logic                 rx_done_q;
    logic                 frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_err_q;
`endif
    logic                 rx_s;
    logic                 tick;
    logic                 bit_tick;

    // Two-flop synchroniser. Both flops reset to the idle level, so the
    // release of reset never looks like a start edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= 2'b11;
        end else begin
            // NOTE: non-blocking assignment lets each flop capture the value
            // its neighbour held before this edge. Blocking assignment would
            // collapse the chain into one stage.
            sync_q <= {sync_q[0], i_rx};
        end
    end

    assign rx_s     = sync_q[1];
    assign tick     = (div_cnt_q == DIV_LAST);
    // One full bit time has elapsed since the previous bit-centre sample.
    assign bit_tick = tick && (os_cnt_q == OS_LAST);

    // Sample-tick divider. It is held at zero while no frame is in progress,
    // so the k-th tick after a detect falls exactly k*DIV_SAMPLE cycles later.
    always_comb begin
        // NOTE: a default assignment on every path keeps this block purely
        // combinational. Without it, a missed branch would infer a latch.
        div_cnt_d = div_cnt_q + 1'b1;
        if (state_q == S_IDLE || state_q == S_WAIT_IDLE || !i_rx_en || tick) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // Receive FSM with registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            os_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            // NOTE: the shift register is reset along with the control state.
            // No code path ever exposes it before it is refilled, but a
            // defined value keeps simulation free of X after reset.
            shift_q     <= '0;
            data_q      <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;

            if (state_q != S_IDLE && !i_rx_en) begin
                // Abort silently; o_data keeps its last good byte.
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (i_rx_en && !rx_s) begin
                            state_q   <= S_START;
                            os_cnt_q  <= '0;
                            bit_cnt_q <= '0;
                        end
                    end

                    S_START: begin
                        if (tick) begin
                            if (os_cnt_q == OS_MID) begin
                                os_cnt_q <= '0;
                                // Still high at the midpoint means it was a glitch.
                                state_q  <= rx_s ? S_IDLE : S_DATA;
                            end else begin
                                os_cnt_q <= os_cnt_q + 1'b1;
                            end
                        end
                    end

                    S_DATA: begin
                        if (tick) begin
                            os_cnt_q <= os_cnt_q + 1'b1;
                        end
                        if (bit_tick) begin
                            os_cnt_q <= '0;
                            // The LSB arrives first. Shifting right places it
                            // at bit 0 once all bits are in.
                            shift_q  <= {rx_s, shift_q[SIZE_DATA-1:1]};
                            if (bit_cnt_q == BIT_LAST) begin
                                bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                                state_q   <= S_PARITY;
`else
                                state_q   <= S_STOP;
`endif
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end

`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (tick) begin
                            os_cnt_q <= os_cnt_q + 1'b1;
                        end
                        if (bit_tick) begin
                            os_cnt_q  <= '0;
                            // Even parity: data bits plus the parity bit XOR to 0.
                            par_err_q <= rx_s ^ (^shift_q);
                            state_q   <= S_STOP;
                        end
                    end
`endif

                    S_STOP: begin
                        if (tick) begin
                            os_cnt_q <= os_cnt_q + 1'b1;
                        end
                        if (bit_tick) begin
                            os_cnt_q <= '0;
                            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                                if (par_err_q) begin
                                    frame_err_q <= 1'b1;
                                end else begin
                                    data_q    <= shift_q;
                                    rx_done_q <= 1'b1;
                                end
`else
                                data_q    <= shift_q;
                                rx_done_q <= 1'b1;
`endif
                                state_q <= S_IDLE;
                            end else begin
                                // A low stop bit may be a break. Wait for the
                                // line to idle so the break is not decoded as
                                // a run of 0x00 frames.
                                frame_err_q <= 1'b1;
                                state_q     <= S_WAIT_IDLE;
                            end
                        end
                    end

                    S_WAIT_IDLE: begin
                        if (rx_s) begin
                            state_q <= S_IDLE;
                        end
                    end

                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign o_data      = data_q;
    assign o_rx_done   = rx_done_q;
    assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_os16 -- self-checking bench for uart_rx_os16
//
// The receiver runs with a reduced DIV_SAMPLE so that a frame lasts a few
// hundred clocks. Frames are described at bit level: start, data LSB first,
// optional even parity, stop. The expected outcome of each frame is derived
// from that description. A good frame updates the byte and yields one done
// pulse. A bad stop bit or parity mismatch yields one error pulse. Either
// pulse appears one cycle after the stop-bit centre, counted from the start
// edge.
// ----------------------------------------------------------------------------
module tb_uart_rx_os16;

    localparam int SIZE_DATA   = 8;
    localparam int OVER_SAMPLE = 16;
    localparam int MID_SAMPLE  = 8;
    localparam int DIV_SAMPLE  = 5;
    localparam int BIT_CLKS    = OVER_SAMPLE * DIV_SAMPLE;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS    = 1;
`else
    localparam int PAR_BITS    = 0;
`endif
    // Tick index of the stop-bit centre, counted from the detect cycle.
    localparam int STOP_TICK   = MID_SAMPLE + OVER_SAMPLE * (SIZE_DATA + 1 + PAR_BITS);
    // Start edge -> detect (2-flop synchroniser) -> stop sample -> registered pulse.
    localparam int PULSE_LAT   = 2 + STOP_TICK * DIV_SAMPLE + 1;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 rx_en = 1'b0;
    logic                 rx    = 1'b1;
    logic [SIZE_DATA-1:0] data;
    logic                 rx_done;
    logic                 frame_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int done_cnt  = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    int done_cyc  = -1;
    int err_cyc   = -1;
    logic [SIZE_DATA-1:0] exp_data = '0;

    uart_rx_os16 #(
        .SIZE_DATA  (SIZE_DATA),
        .OVER_SAMPLE(OVER_SAMPLE),
        .MID_SAMPLE (MID_SAMPLE),
        .DIV_SAMPLE (DIV_SAMPLE)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx_en    (rx_en),
        .i_rx       (rx),
        .o_data     (data),
        .o_rx_done  (rx_done),
        .o_frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (frame_err) begin
                err_cnt <= err_cnt + 1;
                err_cyc <= cyc;
            end
            if (rx_done && frame_err) begin
                both_cnt <= both_cnt + 1;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge, well clear of sampling.
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input logic [SIZE_DATA-1:0] b, input logic stop_bit,
                               input logic par_flip, output int n0);
        n0 = cyc;
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < SIZE_DATA; i++) begin
            rx = b[i];
            wait_clks(BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        wait_clks(BIT_CLKS);
`else
        if (par_flip) rx = 1'b1;
`endif
        rx = stop_bit;
        wait_clks(BIT_CLKS);
    endtask

    // Send one frame and compare the receiver's reaction against the frame's
    // expected outcome.
    task automatic run_frame(input string tag, input logic [SIZE_DATA-1:0] b,
                             input logic stop_bit, input logic par_flip);
        int  d0;
        int  e0;
        int  n0;
        bit  good;
        d0   = done_cnt;
        e0   = err_cnt;
        good = stop_bit && (PAR_BITS == 0 || !par_flip);
        drive_frame(b, stop_bit, par_flip, n0);
        if (good) exp_data = b;
        check({tag, " done pulses"}, done_cnt - d0, good ? 1 : 0);
        check({tag, " ferr pulses"}, err_cnt - e0, good ? 0 : 1);
        check({tag, " data"}, int'(data), int'(exp_data));
        if (good) check({tag, " done cycle"}, done_cyc, n0 + PULSE_LAT);
        else      check({tag, " ferr cycle"}, err_cyc, n0 + PULSE_LAT);
    endtask

    initial begin
        int                   d0;
        int                   e0;
        int                   n0;
        logic [SIZE_DATA-1:0] b;
        logic                 stop_bit;
        logic                 flip;

        // Reset state.
        wait_clks(5);
        check("reset data", int'(data), 0);
        check("reset done", int'(rx_done), 0);
        check("reset ferr", int'(frame_err), 0);
        rst_n = 1'b1;
        rx_en = 1'b1;
        wait_clks(10);

        // Plain good frame.
        run_frame("f29", 8'h29, 1'b1, 1'b0);
        rx = 1'b1;
        wait_clks(BIT_CLKS);

        // Short low glitch on an idle line, rejected at the start midpoint.
        d0 = done_cnt;
        e0 = err_cnt;
        rx = 1'b0;
        wait_clks(4 * DIV_SAMPLE);
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("glitch done pulses", done_cnt - d0, 0);
        check("glitch ferr pulses", err_cnt - e0, 0);
        check("glitch data", int'(data), int'(exp_data));

        // Low stop bit, then the line is released; then a good frame.
        run_frame("f55 bad stop", 8'h55, 1'b0, 1'b0);
        rx = 1'b1;
        wait_clks(BIT_CLKS);
        run_frame("fAA", 8'hAA, 1'b1, 1'b0);
        rx = 1'b1;
        wait_clks(BIT_CLKS);

        // Back-to-back frames with no idle gap.
        run_frame("b2b 00", 8'h00, 1'b1, 1'b0);
        run_frame("b2b FF", 8'hFF, 1'b1, 1'b0);
        rx = 1'b1;
        wait_clks(BIT_CLKS);

        // Receiver disabled for a whole frame.
        rx_en = 1'b0;
        d0 = done_cnt;
        e0 = err_cnt;
        drive_frame(8'h30, 1'b1, 1'b0, n0);
        rx = 1'b1;
        wait_clks(BIT_CLKS);
        check("disabled done pulses", done_cnt - d0, 0);
        check("disabled ferr pulses", err_cnt - e0, 0);
        check("disabled data", int'(data), int'(exp_data));

        // Enable mid-frame, then assert reset at bit 4.
        b  = 8'h30;
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < SIZE_DATA; i++) begin
            if (i == 2) rx_en = 1'b1;
            rx = b[i];
            if (i == 4) begin
                rst_n = 1'b0;
                wait_clks(3);
                check("midreset data", int'(data), 0);
                check("midreset done", int'(rx_done), 0);
                check("midreset ferr", int'(frame_err), 0);
                wait_clks(BIT_CLKS - 3);
            end else begin
                wait_clks(BIT_CLKS);
            end
        end
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        rst_n    = 1'b1;
        exp_data = '0;
        wait_clks(10);
        check("after reset data", int'(data), 0);
        run_frame("f3C", 8'h3C, 1'b1, 1'b0);
        rx = 1'b1;
        wait_clks(BIT_CLKS);

`ifdef UART_RX_PARITY_EN
        run_frame("par ok 3C", 8'h3C, 1'b1, 1'b0);
        rx = 1'b1;
        wait_clks(BIT_CLKS);
        run_frame("par bad 3C", 8'h3C, 1'b1, 1'b1);
        rx = 1'b1;
        wait_clks(BIT_CLKS);
`endif

        // Random frames with random idle gaps and occasional bad stop bits.
        for (int k = 0; k < 8; k++) begin
            b        = SIZE_DATA'($urandom_range(0, 255));
            stop_bit = ($urandom_range(0, 4) != 0);
            flip     = (PAR_BITS != 0) && ($urandom_range(0, 3) == 0);
            run_frame($sformatf("rnd%0d %02h", k, b), b, stop_bit, flip);
            rx = 1'b1;
            wait_clks(BIT_CLKS + int'($urandom_range(0, BIT_CLKS)));
        end

        check("done and ferr overlap", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
